m_serial_adder: RTL and testbench
=================================

M_SERIAL_ADDER -- requirements
Module: m_serial_adder

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL have parameter: WIDTH, 8, operand/sum width in bits (legal range 2..32).
REQ-003 SHALL have port: w_clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port: w_rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port: w_in_valid  input  1  operand set offered.
REQ-006 SHALL have port: w_in_ready  output  1  block can accept operands.
REQ-007 SHALL have ports: w_a, w_b  input  WIDTH  addends, unsigned or two's complement.
REQ-008 SHALL have port: w_cin  input  1  carry-in.
REQ-009 SHALL have port: w_out_valid  output  1  result available.
REQ-010 SHALL have port: w_out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: w_s  output  WIDTH  sum.
REQ-012 SHALL have port: w_cout  output  1  carry-out.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-014 In IDLE SHALL drive w_in_ready=1; all other states w_in_ready=0.
REQ-015 On w_in_valid&w_in_ready, SHALL load w_a/w_b into shift registers, carry FF <= w_cin, bit counter <= 0, go to RUN.
REQ-016 In RUN SHALL, each cycle, add LSB of A, LSB of B and carry FF through one full-adder cell, shift sum bit into MSB of sum register, shift A/B right, carry FF <= cell carry, counter++.
REQ-017 SHALL leave RUN for DONE on the cycle the counter reaches WIDTH-1, i.e. exactly WIDTH RUN cycles.
REQ-018 Latency: accept at edge t SHALL yield w_out_valid=1 after edge t+WIDTH.
REQ-019 In DONE SHALL drive w_out_valid=1, w_s=sum register, w_cout=carry FF, held stable until w_out_ready=1.
REQ-020 On w_out_valid&w_out_ready SHALL return to IDLE; w_s/w_cout keep last value; w_out_valid=0 next cycle.
REQ-021 w_in_valid outside IDLE SHALL be ignored; no back-to-back overlap (new accept earliest one cycle after DONE handshake).
REQ-022 w_s and w_cout SHALL equal {cout,s} = a+b+cin modulo 2^(WIDTH+1) for all inputs.

Reset
REQ-023 When w_rst_n=0 at an edge SHALL force IDLE, w_out_valid=0, w_s=0, w_cout=0, counter=0, carry FF=0, regardless of state.
REQ-024 Reset mid-RUN or in DONE SHALL discard the operation; no w_out_valid for it.

Configuration
REQ-025 Macro M_SERIAL_ADDER_OVF_EN defined: SHALL add output w_ovf (1 bit) = carry into MSB XOR carry out, captured on final RUN cycle, valid with w_out_valid, reset 0.
REQ-026 Macro undefined: SHALL have no w_ovf port and no related logic; all other behaviour identical.

Structure
REQ-027 FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in shared package m_arith_pkg.
REQ-028 SHALL instantiate the team's full-adder cell m_FA once as the sole adder datapath; no WIDTH-bit '+' operator.

Verification (WIDTH=8)
REQ-029 Reset held 2 cycles -> w_in_ready=1, w_out_valid=0, w_s=8'h00, w_cout=0.
REQ-030 a=8'h35, b=8'h4A, cin=0 accepted at edge t -> w_out_valid=1 after edge t+8, w_s=8'h7F, w_cout=0.
REQ-031 a=8'hFF, b=8'h01, cin=0 -> w_s=8'h00, w_cout=1, w_ovf=0 (with macro).
REQ-032 a=8'h7F, b=8'h00, cin=1 -> w_s=8'h80, w_cout=0, w_ovf=1 (with macro).
REQ-033 w_out_ready low 5 cycles in DONE, w_in_valid=1 with new operands -> w_s/w_cout unchanged, w_in_ready=0, new operands not taken until after handshake.
REQ-034 w_rst_n=0 on 3rd RUN cycle -> IDLE next edge, all outputs 0, no w_out_valid; following a=8'h10,b=8'h20 -> w_s=8'h30.

Source files
------------

// File: rtl/m_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m_arith_pkg
//  Description : Shared arithmetic definitions. Provides the FSM state
//                encoding for the serial adder and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package m_arith_pkg;

  // Serial-adder control states; encodings are fixed so that other blocks
  // and debug tooling can decode the state register directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold the values 0..width-1.
  // A one-bit counter is still used for the degenerate width of 1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : m_arith_pkg
`default_nettype wire

// File: rtl/m_FA.sv
`default_nettype none
// ============================================================================
//  Module      : m_FA
//  Description : Single-bit full-adder cell. Pure combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module m_FA (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_prop;

  // Propagate term is shared between the sum and the carry.
  assign w_prop = i_a ^ i_b;
  assign o_s    = w_prop ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_prop);

endmodule : m_FA
`default_nettype wire

// File: rtl/m_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : m_serial_adder
//  Description : Bit-serial adder. Accepts WIDTH-bit operands plus carry-in
//                with a valid/ready handshake, adds them LSB first through a
//                single full-adder cell over WIDTH cycles, then presents
//                {cout, s} = a + b + cin with a valid/ready handshake.
//  Options     : M_SERIAL_ADDER_OVF_EN - adds the w_ovf output (signed
//                overflow = carry into MSB XOR carry out).
//  Revision    : 1.0 - initial release
// ============================================================================
module m_serial_adder
  import m_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_in_valid,
  output logic             w_in_ready,
  input  logic [WIDTH-1:0] w_a,
  input  logic [WIDTH-1:0] w_b,
  input  logic             w_cin,
  output logic             w_out_valid,
  input  logic             w_out_ready,
  output logic [WIDTH-1:0] w_s,
  output logic             w_cout
`ifdef M_SERIAL_ADDER_OVF_EN
  ,
  output logic             w_ovf
`endif
);

  localparam int unsigned c_CNT_W = cnt_width(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_accept;
  logic               w_running;
  logic               w_last;
  logic               w_fa_s;
  logic               w_fa_cout;

  assign w_accept  = w_in_valid & w_in_ready;
  assign w_running = (r_state == RUN);
  assign w_last    = w_running & (r_cnt == c_CNT_LAST);

  // The only adder in the datapath: one bit per RUN cycle, LSBs first.
  m_FA u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_s    (w_fa_s),
    .o_cout (w_fa_cout)
  );

  // State register.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (w_in_valid) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (w_out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand shifters, sum shifter, carry flop and bit counter. The sum
  // enters at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= w_a;
      r_b     <= w_b;
      r_carry <= w_cin;
      r_cnt   <= '0;
    end else if (w_running) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
      r_carry <= w_fa_cout;
      r_cnt   <= r_cnt + c_CNT_W'(1);
    end
  end

  // Result is presented straight from the sum register and carry flop; they
  // are frozen outside RUN, so the values hold through DONE and afterwards.
  assign w_s    = r_sum;
  assign w_cout = r_carry;

`ifdef M_SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // On the final bit the cell's carry-in is the carry into the MSB.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_fa_cout;
    end
  end

  assign w_ovf = r_ovf;
`endif

endmodule : m_serial_adder
`default_nettype wire

// File: tb/tb_m_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_serial_adder
//  Description : Directed self-checking bench for m_serial_adder, WIDTH=8.
//                Expected values are hand-computed constants.
//  Options     : M_SERIAL_ADDER_OVF_EN - also checks w_ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m_serial_adder;

  localparam int WIDTH = 8;

  logic             w_clk;
  logic             w_rst_n;
  logic             w_in_valid;
  logic             w_in_ready;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic             w_out_valid;
  logic             w_out_ready;
  logic [WIDTH-1:0] w_s;
  logic             w_cout;
`ifdef M_SERIAL_ADDER_OVF_EN
  logic             w_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  m_serial_adder #(.WIDTH(WIDTH)) dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .w_in_valid  (w_in_valid),
    .w_in_ready  (w_in_ready),
    .w_a         (w_a),
    .w_b         (w_b),
    .w_cin       (w_cin),
    .w_out_valid (w_out_valid),
    .w_out_ready (w_out_ready),
    .w_s         (w_s),
    .w_cout      (w_cout)
`ifdef M_SERIAL_ADDER_OVF_EN
    ,
    .w_ovf       (w_ovf)
`endif
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
    end
  endtask

  // One rising edge, then return at the falling edge where inputs change
  // and outputs are sampled.
  task automatic tick;
    @(posedge w_clk);
    @(negedge w_clk);
  endtask

  // Counts edges until w_out_valid is seen, bounded.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!w_out_valid && cyc < 40) begin
      tick;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] es, input logic ec,
                        input logic eo);
    int cyc;
    w_a        = a;
    w_b        = b;
    w_cin      = cin;
    w_in_valid = 1'b1;
    check_eq({tag, "_rdy"}, 32'(w_in_ready), 32'h1);
    tick;
    w_in_valid = 1'b0;
    check_eq({tag, "_busy"}, 32'(w_in_ready), 32'h0);
    wait_valid(cyc);
    check_eq({tag, "_lat"}, 32'(cyc), 32'd8);
    check_eq({tag, "_s"}, 32'(w_s), 32'(es));
    check_eq({tag, "_cout"}, 32'(w_cout), 32'(ec));
`ifdef M_SERIAL_ADDER_OVF_EN
    check_eq({tag, "_ovf"}, 32'(w_ovf), 32'(eo));
`else
    if (eo === 1'bz) $display("note: unexpected z on ovf argument");
`endif
    w_out_ready = 1'b1;
    tick;
    w_out_ready = 1'b0;
    check_eq({tag, "_drop"}, 32'(w_out_valid), 32'h0);
    check_eq({tag, "_hold"}, 32'({w_cout, w_s}), 32'({ec, es}));
  endtask

  initial begin
    int  cyc;
    logic seen;

    w_rst_n     = 1'b0;
    w_in_valid  = 1'b0;
    w_a         = '0;
    w_b         = '0;
    w_cin       = 1'b0;
    w_out_ready = 1'b0;

    // Reset held two cycles.
    tick;
    tick;
    check_eq("rst_in_ready", 32'(w_in_ready), 32'h1);
    check_eq("rst_out_valid", 32'(w_out_valid), 32'h0);
    check_eq("rst_s", 32'(w_s), 32'h00);
    check_eq("rst_cout", 32'(w_cout), 32'h0);
    w_rst_n = 1'b1;
    tick;

    //      tag     a      b      cin   s      cout  ovf
    run_op("v35",  8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_op("vFF",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("v7F",  8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    run_op("v80",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("vA5",  8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op("vC3",  8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b0);

    // Consumer stalls in DONE while a new operand set is offered.
    w_a = 8'h12; w_b = 8'h34; w_cin = 1'b0; w_in_valid = 1'b1;
    tick;
    w_a = 8'h0F; w_b = 8'hF1; w_cin = 1'b1;
    wait_valid(cyc);
    check_eq("stall_lat", 32'(cyc), 32'd8);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_state", 32'({w_out_valid, w_in_ready, w_cout, w_s}),
               32'({1'b1, 1'b0, 1'b0, 8'h46}));
      tick;
    end
    w_out_ready = 1'b1;
    tick;
    w_out_ready = 1'b0;
    check_eq("stall_drop", 32'(w_out_valid), 32'h0);
    check_eq("stall_ready", 32'(w_in_ready), 32'h1);
    check_eq("stall_hold", 32'({w_cout, w_s}), 32'({1'b0, 8'h46}));
    tick;
    w_in_valid = 1'b0;
    wait_valid(cyc);
    check_eq("next_lat", 32'(cyc), 32'd8);
    check_eq("next_sum", 32'({w_cout, w_s}), 32'({1'b1, 8'h01}));
`ifdef M_SERIAL_ADDER_OVF_EN
    check_eq("next_ovf", 32'(w_ovf), 32'h0);
`endif
    w_out_ready = 1'b1;
    tick;
    w_out_ready = 1'b0;

    // Reset asserted during the third RUN cycle aborts the operation.
    w_a = 8'h55; w_b = 8'h22; w_cin = 1'b0; w_in_valid = 1'b1;
    tick;
    w_in_valid = 1'b0;
    tick;
    tick;
    w_rst_n = 1'b0;
    tick;
    check_eq("abort_in_ready", 32'(w_in_ready), 32'h1);
    check_eq("abort_out_valid", 32'(w_out_valid), 32'h0);
    check_eq("abort_s", 32'(w_s), 32'h00);
    check_eq("abort_cout", 32'(w_cout), 32'h0);
`ifdef M_SERIAL_ADDER_OVF_EN
    check_eq("abort_ovf", 32'(w_ovf), 32'h0);
`endif
    w_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (w_out_valid) seen = 1'b1;
      tick;
    end
    check_eq("abort_no_valid", 32'(seen), 32'h0);
    run_op("v10",  8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_m_serial_adder
`default_nettype wire
